// File: rtl/ram_arb_pkg.sv
// ============================================================
// ram_arb_pkg: shared types and defaults for the RAM arbiter
// Revision 1.0
// ============================================================
`default_nettype none

package ram_arb_pkg;

    localparam int DEFAULT_MEM_DEPTH = 4096;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================
// rr_arb2: two-requester round-robin decision (combinational)
// Revision 1.0
// ============================================================
`default_nettype none

module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,        // [0] instruction side, [1] data side
    input  grant_t     last_grant,
    output grant_t     grant
);

    always_comb begin
        grant = GNT_I;
        if (req == 2'b11) begin
            grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (req[1]) begin
            grant = GNT_D;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================
// ram_arbiter: round-robin arbitration of I/D requesters onto one RAM
// Revision 1.0
// ============================================================
`default_nettype none

module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    localparam int AW        = $clog2(MEM_DEPTH) - 3
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          i_req,
    input  logic [63:0]   i_addr,
    output logic          i_rvalid,
    output logic [63:0]   i_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [63:0]   d_addr,
    input  logic [63:0]   d_wdata,
    input  logic [7:0]    d_wmask,
    output logic          d_rvalid,
    output logic [63:0]   d_rdata,

    output logic          ram_ren,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [63:0]   ram_wdata,
    output logic [7:0]    ram_wmask,
    input  logic [63:0]   ram_rdata,
    input  logic          ram_valid
);

    state_t state;
    state_t state_next;
    grant_t last_grant;
    grant_t grant;

    // Only the word-address bits inside the RAM matter; the rest wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[63:AW+3], i_addr[2:0],
                                d_addr[63:AW+3], d_addr[2:0]};

    rr_arb2 u_rr_arb2 (
        .req        ({d_req, i_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_next = (grant == GNT_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (ram_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Completion is combinational on ram_valid; ram_valid seen in IDLE is dropped.
    assign i_rvalid = (state == BUSY_I) && ram_valid;
    assign d_rvalid = (state == BUSY_D) && ram_valid;
    assign i_rdata  = i_rvalid ? ram_rdata : 64'd0;
    assign d_rdata  = (d_rvalid && ram_ren) ? ram_rdata : 64'd0;

    // The RAM command registers double as the latched request payload.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= GNT_I;
            ram_ren    <= 1'b0;
            ram_wen    <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_wmask  <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && (state_next != IDLE)) begin
                last_grant <= grant;
                if (grant == GNT_D) begin
                    ram_ren   <= ~d_we;
                    ram_wen   <= d_we;
                    ram_addr  <= d_addr[AW+2:3];
                    ram_wdata <= d_wdata;
                    ram_wmask <= d_wmask;
                end else begin
                    ram_ren   <= 1'b1;
                    ram_wen   <= 1'b0;
                    ram_addr  <= i_addr[AW+2:3];
                    ram_wdata <= '0;
                    ram_wmask <= '0;
                end
            end else if (state_next == IDLE) begin
                ram_ren   <= 1'b0;
                ram_wen   <= 1'b0;
                ram_addr  <= '0;
                ram_wdata <= '0;
                ram_wmask <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a 1-cycle RAM model
// Revision 1.0
// ============================================================
`default_nettype none

module tb_ram_arbiter;

    localparam int AW = 9;
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_req, d_req, d_we;
    logic [63:0]   i_addr, d_addr, d_wdata;
    logic [7:0]    d_wmask;
    logic          i_rvalid, d_rvalid;
    logic [63:0]   i_rdata, d_rdata;
    logic          ram_ren, ram_wen;
    logic [AW-1:0] ram_addr;
    logic [63:0]   ram_wdata;
    logic [7:0]    ram_wmask;
    logic [63:0]   ram_rdata;
    logic          ram_valid;
    logic          mdl_valid;
    logic          inject;

    logic [63:0]   mem [0:(1<<AW)-1];

    typedef struct {
        logic        side;
        logic [63:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.MEM_DEPTH(4096)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wmask (ram_wmask),
        .ram_rdata (ram_rdata),
        .ram_valid (ram_valid)
    );

    assign ram_valid = mdl_valid | inject;

    // RAM model: answers one cycle after a command; contents restored while in reset.
    always @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < (1 << AW); k++) mem[k] <= 64'd0;
            mem[0]    <= 64'h0123_4567_89AB_CDEF;
            mem[1]    <= 64'hA5A5_5A5A_1234_5678;
            mdl_valid <= 1'b0;
            ram_rdata <= 64'd0;
        end else if ((ram_ren || ram_wen) && !mdl_valid) begin
            mdl_valid <= 1'b1;
            ram_rdata <= ram_ren ? mem[ram_addr] : 64'd0;
            if (ram_wen) begin
                for (int b = 0; b < 8; b++)
                    if (ram_wmask[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end else begin
            mdl_valid <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        if (rstn) begin
            check("ren_wen_exclusive", {63'd0, ram_ren & ram_wen}, 64'd0);
            if (!i_rvalid) check("i_rdata_quiet", i_rdata, 64'd0);
            if (!d_rvalid) check("d_rdata_quiet", d_rdata, 64'd0);
            if (i_rvalid || d_rvalid) begin
                if (i_rvalid && d_rvalid) begin
                    check("both_rvalid", 64'd1, 64'd0);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", {63'd0, d_rvalid}, {63'd0, ~d_rvalid});
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rvalid_side", {63'd0, d_rvalid}, {63'd0, e.side});
                    check("rdata", d_rvalid ? d_rdata : i_rdata, e.data);
                end
            end
        end
    end

    task automatic txn(input string name, input logic side, input logic we,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask, input logic [63:0] exp_data,
                       input logic [AW-1:0] exp_ra);
        int lat;
        bit seen;
        @(posedge clk); #1;
        exp_q.push_back('{side: side, data: exp_data});
        if (side == SIDE_D) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wmask = wmask;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        @(posedge clk); #1;
        check({name, "_ren"},  {63'd0, ram_ren}, {63'd0, (side == SIDE_D) ? ~we : 1'b1});
        check({name, "_wen"},  {63'd0, ram_wen}, {63'd0, (side == SIDE_D) ? we : 1'b0});
        check({name, "_addr"}, {55'd0, ram_addr}, {55'd0, exp_ra});
        if (side == SIDE_D && we) check({name, "_wmask"}, {56'd0, ram_wmask}, {56'd0, wmask});
        // lat counts cycles after the request cycle; rvalid belongs in the third cycle.
        lat  = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if ((side == SIDE_D) ? d_rvalid : i_rvalid) seen = 1;
        end
        if (side == SIDE_D) d_req = 1'b0; else i_req = 1'b0;
        if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
        else       check({name, "_latency"}, 64'(lat), 64'd2);
    endtask

    initial begin
        int n;
        rstn = 1'b0; inject = 1'b0;
        i_req = 1'b1; i_addr = 64'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h208; d_wdata = 64'd0; d_wmask = 8'd0;

        // Reset with both requests already high
        repeat (3) @(posedge clk);
        #1;
        check("rst_ren",      {63'd0, ram_ren},  64'd0);
        check("rst_wen",      {63'd0, ram_wen},  64'd0);
        check("rst_addr",     {55'd0, ram_addr}, 64'd0);
        check("rst_wdata",    ram_wdata,         64'd0);
        check("rst_wmask",    {56'd0, ram_wmask}, 64'd0);
        check("rst_i_rvalid", {63'd0, i_rvalid}, 64'd0);
        check("rst_d_rvalid", {63'd0, d_rvalid}, 64'd0);

        // Contention: D wins first, then alternation D,I,D,I
        exp_q.push_back('{side: SIDE_D, data: 64'd0});
        exp_q.push_back('{side: SIDE_I, data: 64'h0123_4567_89AB_CDEF});
        exp_q.push_back('{side: SIDE_D, data: 64'd0});
        exp_q.push_back('{side: SIDE_I, data: 64'h0123_4567_89AB_CDEF});
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (i_rvalid || d_rvalid) n++;
        end
        i_req = 1'b0; d_req = 1'b0;
        check("contention_count", 64'(n), 64'd4);

        // D write with byte mask, then read back with d_req dropped after grant
        txn("d_write", SIDE_D, 1'b1, 64'h208, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'd0, 9'h041);

        @(posedge clk); #1;
        exp_q.push_back('{side: SIDE_D, data: 64'h0000_0000_FFFF_FFFF});
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h208; d_wmask = 8'h00;
        @(posedge clk); #1;
        check("d_drop_ren", {63'd0, ram_ren}, 64'd1);
        d_req = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && n == 0; k++) begin
            @(negedge clk);
            if (d_rvalid) n++;
        end
        check("d_drop_done", 64'(n), 64'd1);
        @(posedge clk); #1;
        check("d_drop_idle", {62'd0, ram_ren, ram_wen}, 64'd0);

        // Single I read at 0x1000 (wraps onto word 0 with a 4 KiB RAM)
        txn("i_read", SIDE_I, 1'b0, 64'h1000, 64'd0, 8'd0, 64'h0123_4567_89AB_CDEF, 9'h000);

        // Stray ram_valid while idle must not complete anything
        @(posedge clk); #1;
        inject = 1'b1;
        @(negedge clk);
        check("stray_valid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
        @(posedge clk); #1;
        inject = 1'b0;
        check("stray_idle", {62'd0, ram_ren, ram_wen}, 64'd0);

        // Reset in the middle of BUSY_I aborts without a completion
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 64'h8;
        @(posedge clk); #1;
        check("abort_busy", {63'd0, ram_ren}, 64'd1);
        i_req = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("abort_ren",    {63'd0, ram_ren},  64'd0);
        check("abort_addr",   {55'd0, ram_addr}, 64'd0);
        check("abort_rvalid", {63'd0, i_rvalid}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("abort_quiet", {62'd0, ram_ren, ram_wen}, 64'd0);
        txn("i_reissue", SIDE_I, 1'b0, 64'h8, 64'd0, 8'd0, 64'hA5A5_5A5A_1234_5678, 9'h001);

        // Upper address bits ignored
        txn("i_wrap", SIDE_I, 1'b0, 64'h1_0000_1000, 64'd0, 8'd0, 64'h0123_4567_89AB_CDEF, 9'h000);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 4096, RAM size in bytes; AW = $clog2(MEM_DEPTH)-3 is the word-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_req  input  1, i_addr  input  64  instruction-side read request and byte address.
REQ-005 SHALL have ports i_rvalid  output  1, i_rdata  output  64  instruction-side completion pulse and read data.
REQ-006 SHALL have ports d_req  input  1, d_we  input  1, d_addr  input  64, d_wdata  input  64, d_wmask  input  8  data-side request (d_we=1 write, 0 read).
REQ-007 SHALL have ports d_rvalid  output  1, d_rdata  output  64  data-side completion pulse (reads and writes) and read data.
REQ-008 SHALL have ports ram_ren  output  1, ram_wen  output  1, ram_addr  output  AW, ram_wdata  output  64, ram_wmask  output  8  shared-RAM command.
REQ-009 SHALL have ports ram_rdata  input  64, ram_valid  input  1  shared-RAM read data and completion.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-011 In IDLE with only i_req=1 SHALL go to BUSY_I next edge; with only d_req=1 to BUSY_D.
REQ-012 In IDLE with i_req=d_req=1 SHALL grant the side not granted last (round-robin); last_grant resets to I, so D wins the first conflict.
REQ-013 On grant SHALL latch address, d_we, d_wdata, d_wmask into registers; ram_addr = latched addr[AW+2:3]; upper address bits ignored (wrap).
REQ-014 ram_ren/ram_wen/ram_addr/ram_wdata/ram_wmask SHALL be registered outputs, driven only in BUSY_x; in IDLE all are 0.
REQ-015 BUSY_I SHALL drive ram_ren=1, ram_wen=0, ram_wmask=0; BUSY_D SHALL drive ram_wen=latched d_we, ram_ren=~latched d_we.
REQ-016 In BUSY_x with ram_valid=1 SHALL assert x_rvalid combinationally for exactly that cycle, pass ram_rdata to x_rdata, and go to IDLE at the next edge.
REQ-017 x_rdata SHALL be 0 whenever x_rvalid=0; d_rdata on a write completion SHALL be 0.
REQ-018 IDLE SHALL last at least one cycle between transactions so the RAM handshake returns to idle; back-to-back latency = 3 cycles per transaction (grant, wait, valid).
REQ-019 Requester SHALL hold req high until its rvalid; req deasserted mid-transaction SHALL be ignored and the transaction completed.
REQ-020 req held high in the rvalid cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-021 ram_valid while in IDLE SHALL be ignored; no rvalid generated.
REQ-022 Ungranted side SHALL wait with no output activity; no starvation: under continuous contention grants SHALL alternate D,I,D,I.

Reset
REQ-023 rstn=0 SHALL immediately force state=IDLE, last_grant=I, all latched payload registers and all RAM command outputs to 0, i_rvalid=d_rvalid=0.
REQ-024 Reset during BUSY_x SHALL abort the transaction with no rvalid; requester reissues after reset.

Structure
REQ-025 Package ram_arb_pkg SHALL hold the FSM state enum, the grant enum {GNT_I, GNT_D} and the default MEM_DEPTH constant.
REQ-026 Round-robin decision SHALL be a sub-module rr_arb2 (inputs req[1:0], last_grant; output grant), combinational, instantiated once.

Verification
REQ-027 Single I read: preload word 0x1000>>3 = 0x0123456789ABCDEF, i_req with i_addr=0x1000 -> ram_ren high 1 cycle after request, i_rvalid pulses with i_rdata=0x0123456789ABCDEF, 3 cycles after i_req.
REQ-028 D write then read: d_we=1, d_addr=0x208, d_wdata=0xFFFF_FFFF_FFFF_FFFF, d_wmask=0x0F; then read 0x208 -> d_rdata=0x0000_0000_FFFF_FFFF over zero-init word.
REQ-029 Simultaneous i_req/d_req held high from reset -> grant order D,I,D,I; each rvalid one-cycle pulse; no cycle with ram_ren and ram_wen both 1.
REQ-030 d_req dropped one cycle after grant -> transaction still completes, d_rvalid pulses once, then IDLE.
REQ-031 rstn pulsed low during BUSY_I -> outputs 0 within the reset cycle, no i_rvalid, fresh i_req afterward completes normally.
REQ-032 Address wrap: i_addr=0x1_0000_1000 with MEM_DEPTH=4096 -> ram_addr=0x000, same data as address 0x0.
